spike_encoder: RTL and testbench

//  Time-to-first-spike (temporal) encoder feeding the neuron accumulator stage.

---
 rtl/spike_encoder.sv | 96 +++++++++
 tb/tb_spike_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: latches one pixel vector per gamma window and
// fires each non-zero channel once, earlier for brighter channels.
module spike_encoder #(
  parameter int NUM_SPIKES = 8,
  parameter int VBITS      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SPIKES*VBITS-1:0] pixels,
  output logic [NUM_SPIKES-1:0]       spikes_out,
  output logic                        window_end,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  // Handshake: a vector transfers on a rising edge where in_valid & in_ready.
  // in_ready is offered only in IDLE and FLUSH, never during RUN or while
  // clear or reset is asserted; pixels are sampled only on that edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [VBITS-1:0] MAXV = '1;
  localparam logic [VBITS-1:0] LAST = MAXV - VBITS'(1);

  state_t                             state, state_next;
  logic [VBITS-1:0]                   tick, tick_next;
  logic [NUM_SPIKES-1:0][VBITS-1:0]   pix;
  logic                               accept;

  assign in_ready  = rst_n & ~clear & ((state == IDLE) | (state == FLUSH));
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    tick_next  = tick;
    if (clear) begin
      state_next = IDLE;
      tick_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_next = RUN;
            tick_next  = '0;
          end
        end
        RUN: begin
          if (tick == LAST) state_next = FLUSH;
          tick_next = tick + VBITS'(1);
        end
        FLUSH: begin
          // Back-to-back windows restart RUN without an idle gap.
          state_next = accept ? RUN : IDLE;
          tick_next  = '0;
        end
        default: begin
          state_next = IDLE;
          tick_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tick  <= '0;
      pix   <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      if (accept) pix <= pixels;
    end
  end

  // Moore decode from registered state only; clear blanks outputs immediately.
  always_comb begin
    spikes_out = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      spikes_out[i] = (state == RUN) && !clear && (pix[i] != '0) &&
                      (tick == MAXV - pix[i]);
    end
  end

  assign window_end = (state == FLUSH) && !clear;

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: per-cycle expectations are queued by the driver
// and popped at the falling edge, when outputs are stable.
module tb_spike_encoder;

  localparam int NS = 8;
  localparam int VB = 3;
  localparam int PW = NS * VB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pixels;
  logic [NS-1:0] spikes_out;
  logic          window_end;
  logic          busy;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // {in_ready, busy, window_end, spikes_out}
  logic [NS+2:0] exp_q[$];

  logic [PW-1:0] v1, v2, v3;

  spike_encoder #(.NUM_SPIKES(NS), .VBITS(VB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixels     (pixels),
    .spikes_out (spikes_out),
    .window_end (window_end),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h required=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic c, input logic [PW-1:0] p);
    in_valid = v;
    clear    = c;
    pixels   = p;
  endtask

  // One cycle: queue the expectation, compare at the falling edge, advance.
  task automatic step(input logic [NS+2:0] e, input string tag);
    logic [NS+2:0] x;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check(tag, {in_ready, busy, window_end, spikes_out}, x);
    end
    @(posedge clk);
    #1;
  endtask

  // Spikes expected in RUN cycle k (1..7) after the handshake: intensity p fires at cycle 8-p.
  function automatic logic [NS-1:0] spk(input logic [PW-1:0] v, input int k);
    logic [NS-1:0] s;
    logic [VB-1:0] p;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      p = v[i*VB +: VB];
      if (p != 0 && int'(p) == 8 - k) s[i] = 1'b1;
    end
    return s;
  endfunction

  // Handshake cycle C0 plus the seven RUN cycles; the caller handles C8 (FLUSH).
  task automatic window(input logic [PW-1:0] v, input logic run_valid,
                        input logic [PW-1:0] run_pix, input logic c0_flush);
    drive(1'b1, 1'b0, v);
    step(c0_flush ? {1'b1, 1'b1, 1'b1, 8'h00} : {1'b1, 1'b0, 1'b0, 8'h00}, "c0");
    for (int k = 1; k <= 7; k++) begin
      drive(run_valid, 1'b0, run_pix);
      step({1'b0, 1'b1, 1'b0, spk(v, k)}, $sformatf("run_k%0d", k));
    end
  endtask

  task automatic flush_then_idle();
    drive(1'b0, 1'b0, '0);
    step({1'b1, 1'b1, 1'b1, 8'h00}, "flush");
    step({1'b1, 1'b0, 1'b0, 8'h00}, "idle_after");
  endtask

  initial begin
    logic          ff;
    logic [PW-1:0] rv;
    // ch7..ch0
    v1 = {3'd0, 3'd5, 3'd2, 3'd7, 3'd1, 3'd3, 3'd0, 3'd7};
    v2 = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    v3 = {3'd6, 3'd6, 3'd0, 3'd3, 3'd3, 3'd7, 3'd4, 3'd2};

    // reset block
    rst_n = 1'b0;
    drive(1'b1, 1'b0, v1);
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_window_end", window_end, 0);
    check("rst_spikes", spikes_out, 0);
    drive(1'b0, 1'b0, '0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step({1'b1, 1'b0, 1'b0, 8'h00}, "idle_after_reset");

    // single window
    window(v1, 1'b0, '0, 1'b0);
    flush_then_idle();

    // back-to-back: second vector held through RUN, accepted in FLUSH
    window(v1, 1'b1, v2, 1'b0);
    window(v2, 1'b0, '0, 1'b1);
    flush_then_idle();

    // pixels toggling during RUN ignored; then an all-zero window
    window(v3, 1'b1, PW'($urandom), 1'b0);
    window('0, 1'b0, '0, 1'b1);
    flush_then_idle();

    // clear in the middle of RUN, on the cycle ch6 would fire
    drive(1'b1, 1'b0, v1);
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t3_c0");
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b0, '0);
      step({1'b0, 1'b1, 1'b0, spk(v1, k)}, "t3_run");
    end
    drive(1'b0, 1'b1, '0);
    step({1'b0, 1'b1, 1'b0, 8'h00}, "t3_clear");
    drive(1'b0, 1'b0, '0);
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t3_idle");
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t3_idle2");

    // clear during FLUSH blocks a pending handshake
    window(v2, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, v1);
    step({1'b0, 1'b1, 1'b0, 8'h00}, "flush_clear");
    drive(1'b0, 1'b0, '0);
    step({1'b1, 1'b0, 1'b0, 8'h00}, "flush_clear_idle");

    // clear and in_valid together in IDLE
    drive(1'b1, 1'b1, v1);
    step({1'b0, 1'b0, 1'b0, 8'h00}, "t5_clear_valid");
    drive(1'b0, 1'b0, '0);
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t5_no_accept");
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t5_no_accept2");

    // random windows, randomly chained
    ff = 1'b0;
    for (int n = 0; n < 8; n++) begin
      rv = '0;
      for (int i = 0; i < NS; i++) rv[i*VB +: VB] = VB'($urandom_range(0, 7));
      window(rv, 1'b0, '0, ff);
      ff = 1'($urandom_range(0, 1));
      if (!ff) flush_then_idle();
    end
    if (ff) flush_then_idle();

    // asynchronous reset between edges during RUN
    drive(1'b1, 1'b0, v1);
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t6_c0");
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b0, '0);
      step({1'b0, 1'b1, 1'b0, spk(v1, k)}, "t6_run");
    end
    #1;
    check("t6_pre_spikes", spikes_out, spk(v1, 3));
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_spikes", spikes_out, 0);
    check("t6_rst_window_end", window_end, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_ready", in_ready, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t6_idle");
    step({1'b1, 1'b0, 1'b0, 8'h00}, "t6_idle2");

    check("queue_drained", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
